// File: rtl/reg_file_mp.sv
// Multi-port register file with a self-initialising INIT sequence, a
// hardwired-zero entry 0, optional same-cycle write-to-read forwarding and
// a registered flag for same-address dual writes.
module reg_file_mp #(
  parameter  int DAT_WIDTH = 32,
  parameter  int DEPTH     = 32,
  parameter  int NUM_RD    = 2,
  parameter  int NUM_WR    = 2,
  parameter  int BYPASS    = 1,
  parameter  int INIT_MODE = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD*AW-1:0]        rd_addr,
  output logic [NUM_RD*DAT_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*AW-1:0]        wr_addr,
  input  logic [NUM_WR*DAT_WIDTH-1:0] wr_data,
  output logic                        ready,
  output logic                        wr_conflict
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t               state;
  logic [AW-1:0]        init_cnt;
  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [DAT_WIDTH-1:0] init_val;

  assign init_val = (INIT_MODE != 0) ? DAT_WIDTH'(init_cnt) : '0;

  // INIT/RUN sequencer: INIT walks every entry once, then ready stays high
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == AW'(DEPTH - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage update: init pattern in INIT, port writes in RUN (later port wins)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_cnt] <= init_val;
      end else begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
            mem[wr_addr[p*AW +: AW]] <= wr_data[p*DAT_WIDTH +: DAT_WIDTH];
          end
        end
      end
    end
  end

  generate
    if (NUM_WR == 2) begin : g_conflict
      // One-cycle pulse after both ports wrote the same non-zero entry in RUN
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_conflict <= 1'b0;
        end else begin
          wr_conflict <= (state == RUN) && wr_en[0] && wr_en[1] &&
                         (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
                         (wr_addr[0 +: AW] != '0);
        end
      end
    end else begin : g_no_conflict
      assign wr_conflict = 1'b0;
    end
  endgenerate

  // Read lanes: stored value, optionally overridden by a matching write
  // (scanned low to high so port 1 has priority), then forced to zero for
  // entry 0 and for the whole INIT phase.
  always_comb begin
    logic [AW-1:0]        ra;
    logic [DAT_WIDTH-1:0] lane;
    rd_data = '0;
    ra      = '0;
    lane    = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      ra   = rd_addr[r*AW +: AW];
      lane = mem[ra];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
            lane = wr_data[p*DAT_WIDTH +: DAT_WIDTH];
          end
        end
      end
      if ((state != RUN) || (ra == '0)) begin
        lane = '0;
      end
      rd_data[r*DAT_WIDTH +: DAT_WIDTH] = lane;
    end
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of registers, a power of 2 and at least 4; AW = log2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports, 1..4.
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports, 1..2.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 enables same-cycle write-to-read forwarding.
REQ-006 SHALL have parameter INIT_MODE, default 1, meaning init value per entry: 0 gives zero, 1 gives the entry index.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-009 SHALL have port rd_addr, input, NUM_RD*AW bits, read addresses, with port i at bits [i*AW +: AW].
REQ-010 SHALL have port rd_data, output, NUM_RD*DAT_WIDTH bits, combinational read data, packed the same way.
REQ-011 SHALL have port wr_en, input, NUM_WR bits, per-port write enable.
REQ-012 SHALL have port wr_addr, input, NUM_WR*AW bits, write addresses.
REQ-013 SHALL have port wr_data, input, NUM_WR*DAT_WIDTH bits, write data.
REQ-014 SHALL have port ready, output, 1 bit, high when the init sequence is done and writes are accepted.
REQ-015 SHALL have port wr_conflict, output, 1 bit, registered one-cycle pulse flagging a same-address dual write.

Function
REQ-016 SHALL implement a two-state FSM with states INIT and RUN.
REQ-017 In INIT, SHALL write the INIT_MODE value to entry init_cnt each cycle and increment init_cnt, where init_cnt is AW bits wide.
REQ-018 SHALL move from INIT to RUN on the cycle that writes entry DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-019 SHALL keep ready = 0 in INIT and ready = 1 in RUN.
REQ-020 In INIT, SHALL ignore all wr_en and drive every rd_data lane to 0.
REQ-021 In RUN, SHALL write entry wr_addr[p] with wr_data[p] at the clock edge when wr_en[p] = 1.
REQ-022 SHALL hardwire entry 0 to 0 in RUN: writes to address 0 are dropped and reads of address 0 return 0, regardless of INIT_MODE.
REQ-023 When both write ports target the same non-zero address in one cycle, port 1 SHALL win and wr_conflict SHALL pulse high in the following cycle.
REQ-024 With BYPASS = 1, a read whose address matches an enabled RUN write to a non-zero address SHALL return that write's data in the same cycle, with port 1 taking priority over port 0.
REQ-025 With BYPASS = 0, reads SHALL return the stored value from before the edge, i.e. the new data is visible one cycle later.
REQ-026 Read ports SHALL be fully independent and any number of them may use the same address.
REQ-027 wr_conflict SHALL be constant 0 when NUM_WR = 1.

Reset
REQ-028 When rst = 1 at a clock edge, SHALL enter INIT with init_cnt = 0, ready = 0 and wr_conflict = 0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from entry 0, and entries not yet re-initialised hold stale data that is unobservable while ready = 0.
REQ-030 After rst is released, ready SHALL rise exactly DEPTH cycles later; the block SHALL have no initial blocks.

Verification
REQ-031 Bench SHALL check: release rst with DEPTH = 32 -> ready rises after exactly 32 cycles; INIT_MODE = 1 then gives rd of address 5 = 5 and rd of address 0 = 0.
REQ-032 Bench SHALL check: in RUN, wr_en = 01, addr 7, data 0xDEADBEEF with rd_addr0 = 7 -> BYPASS = 1 gives 0xDEADBEEF the same cycle; BYPASS = 0 gives 7 the same cycle and 0xDEADBEEF the next.
REQ-033 Bench SHALL check: both ports write address 9 with 0x11 on port 0 and 0x22 on port 1 -> entry 9 = 0x22 and wr_conflict = 1 for one cycle.
REQ-034 Bench SHALL check: write 0xFFFF to address 0 -> rd of address 0 stays 0 and wr_conflict stays 0.
REQ-035 Bench SHALL check: rst asserted at init_cnt = 10, then released -> ready = 0 for a further 32 cycles, and writes attempted during that time are lost.
REQ-036 Bench SHALL check: NUM_RD = 4 with all read ports on address 3 while port 0 writes 0x55 to address 3 -> all four lanes read 0x55 when BYPASS = 1.
